// File: rtl/d_pipe_reg.sv
// Elastic register pipeline: STAGES x WIDTH flops with per-stage valid, bubble collapse, sync flush.
// Latency STAGES-1 edges from accept to out_valid (STAGES=1: same edge); 1 word/cycle throughput.
// Backpressure: out_ready ripples back combinationally; a stage loads only if empty or draining.
module d_pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [$clog2(STAGES+1)-1:0]        occupancy
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES-1:0] en;

    // A stage may load if downstream accepts or any stage from here to the output has a hole.
    // Written as a reduction over the tail rather than a ripple so there is no self-referencing net.
    for (genvar i = 0; i < STAGES; i++) begin : g_en
        assign en[i] = out_ready | ~(&v[STAGES-1:i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= RESET_VAL;
        end else if (flush) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= RESET_VAL;
        end else begin
            if (en[0]) begin
                v[0] <= in_valid;
                if (in_valid) d[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (en[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) d[i] <= d[i-1];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCC_W'(v[i]);
    end

    assign in_ready  = en[0] & ~flush;
    assign out_valid = v[STAGES-1] & ~flush;
    assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_d_pipe_reg.sv
// Bench for d_pipe_reg: positional-queue reference model checked every cycle on two configurations.
module tb_d_pipe_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       a_iv = 1'b0, a_ir, a_ov, a_ordy = 1'b0;
    logic [7:0] a_id = 8'h00, a_od;
    logic [2:0] a_occ;
    logic       b_iv = 1'b0, b_ir, b_ov, b_ordy = 1'b0;
    logic       b_id = 1'b0, b_od;
    logic       b_occ;

    d_pipe_reg #(.WIDTH(8), .STAGES(4), .RESET_VAL(8'h5A)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .occupancy(a_occ)
    );

    d_pipe_reg #(.WIDTH(1), .STAGES(1), .RESET_VAL(1'b1)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .occupancy(b_occ)
    );

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Model: words listed oldest first, each with the stage index it occupies.
    int         mpos [2][4];
    logic [7:0] mdat [2][4];
    int         mcnt [2] = '{0, 0};
    logic [7:0] mlast[2] = '{8'h5A, 8'h01};
    logic       eir_a, eir_b;

    task automatic mstep(input int k, input int s, input logic fl, input logic iv,
                         input logic [7:0] id, input logic ordy, output logic exp_ir);
        int lim;
        exp_ir = 1'b0;
        if (fl) begin
            mcnt[k]  = 0;
            mlast[k] = (k == 0) ? 8'h5A : 8'h01;
            return;
        end
        if (ordy && mcnt[k] > 0 && mpos[k][0] == s - 1) begin
            for (int j = 1; j < mcnt[k]; j++) begin
                mpos[k][j-1] = mpos[k][j];
                mdat[k][j-1] = mdat[k][j];
            end
            mcnt[k]--;
        end
        // Each word advances one slot if the slot ahead is free after the words ahead moved.
        lim = s;
        for (int j = 0; j < mcnt[k]; j++) begin
            if (mpos[k][j] + 1 < lim) begin
                mpos[k][j]++;
                if (mpos[k][j] == s - 1) mlast[k] = mdat[k][j];
            end
            lim = mpos[k][j];
        end
        exp_ir = (lim > 0);
        if (iv && lim > 0) begin
            mpos[k][mcnt[k]] = 0;
            mdat[k][mcnt[k]] = id;
            mcnt[k]++;
            if (s == 1) mlast[k] = id;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mcnt     = '{0, 0};
            mlast[0] = 8'h5A;
            mlast[1] = 8'h01;
        end
        chk("a_out_valid", a_ov, !flush && mcnt[0] > 0 && mpos[0][0] == 3);
        chk("a_occupancy", a_occ, mcnt[0]);
        chk("a_out_data", a_od, mlast[0]);
        chk("b_out_valid", b_ov, !flush && mcnt[1] > 0 && mpos[1][0] == 0);
        chk("b_occupancy", b_occ, mcnt[1]);
        chk("b_out_data", b_od, mlast[1]);
        if (reset) begin
            mstep(0, 4, flush, a_iv, a_id, a_ordy, eir_a);
            mstep(1, 1, flush, b_iv, {7'b0, b_id}, b_ordy, eir_b);
            chk("a_in_ready", a_ir, eir_a);
            chk("b_in_ready", b_ir, eir_b);
        end else begin
            chk("a_in_ready_rst", a_ir, !flush);
            chk("b_in_ready_rst", b_ir, !flush);
        end
    end

    logic [7:0] got[$];
    int         gcyc[$];
    int         first_out;
    int         ir_low;
    logic [2:0] occ_snap;
    logic       ir_snap;

    // Send n words base+1.., optionally on even cycles only, with out_ready low for `stall` cycles.
    task automatic drive_a(input int n, input logic [7:0] base, input bit alt, input int stall);
        int sent = 0;
        int c = 0;
        got.delete();
        gcyc.delete();
        first_out = -1;
        ir_low    = 0;
        while (got.size() < n && c < 300) begin
            @(posedge clk); #1;
            a_iv   = (sent < n) && (!alt || (c % 2 == 0));
            a_id   = base + 8'(sent) + 8'd1;
            a_ordy = (c >= stall);
            #2;
            if (c == stall - 1) begin
                occ_snap = a_occ;
                ir_snap  = a_ir;
            end
            if (a_iv && !a_ir) ir_low++;
            if (a_iv && a_ir) sent++;
            if (a_ov && a_ordy) begin
                if (first_out < 0) first_out = c;
                got.push_back(a_od);
                gcyc.push_back(c);
            end
            c++;
        end
        a_iv = 1'b0;
    endtask

    function automatic int order_errs(input logic [7:0] base, input int n);
        int e = 0;
        if (got.size() != n) return n;
        for (int i = 0; i < n; i++) if (got[i] !== base + 8'(i) + 8'd1) e++;
        return e;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Streaming
        drive_a(16, 8'h00, 1'b0, 0);
        chk("t2_order", order_errs(8'h00, 16), 0);
        chk("t2_first_latency", first_out, 4);
        chk("t2_no_gaps", gcyc[15] - gcyc[0], 15);
        chk("t2_in_ready_low", ir_low, 0);

        // Back-pressure
        drive_a(6, 8'h20, 1'b0, 10);
        chk("t3_occ_stalled", occ_snap, 4);
        chk("t3_in_ready_stalled", ir_snap, 0);
        chk("t3_order", order_errs(8'h20, 6), 0);

        // Bubble collapse
        drive_a(4, 8'h40, 1'b1, 12);
        chk("t4_occ_compacted", occ_snap, 4);
        chk("t4_order", order_errs(8'h40, 4), 0);
        chk("t4_first_out", first_out, 12);
        chk("t4_no_bubbles", gcyc[3] - gcyc[0], 3);

        // Flush
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a_ordy = 1'b0; a_iv = 1'b1; a_id = 8'h51 + 8'(i);
        end
        @(posedge clk); #1; a_iv = 1'b0; #2;
        chk("t5_occ_before", a_occ, 3);
        @(posedge clk); #1; flush = 1'b1; a_iv = 1'b1; a_id = 8'h77; #2;
        chk("t5_in_ready_flush", a_ir, 0);
        chk("t5_out_valid_flush", a_ov, 0);
        @(posedge clk); #1; flush = 1'b0; a_iv = 1'b0; #2;
        chk("t5_occ_after", a_occ, 0);
        chk("t5_out_valid_after", a_ov, 0);
        chk("t5_out_data_after", a_od, 8'h5A);
        drive_a(1, 8'hA9, 1'b0, 0);
        chk("t5_word_aa", got.size() > 0 ? got[0] : 8'h00, 8'hAA);
        chk("t5_latency", first_out, 4);

        // Full with simultaneous in/out
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a_ordy = 1'b0; a_iv = 1'b1; a_id = 8'hC0 + 8'(i);
        end
        @(posedge clk); #1; b_ordy = 1'b0; b_iv = 1'b1; b_id = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a_ordy = 1'b1; a_iv = 1'b1; a_id = 8'($urandom);
            b_ordy = 1'b1; b_iv = 1'b1; b_id = 1'($urandom);
            #2;
            chk("t6_a_occ", a_occ, 4);
            chk("t6_a_in_ready", a_ir, 1);
            chk("t6_a_out_valid", a_ov, 1);
            chk("t6_b_occ", b_occ, 1);
            chk("t6_b_in_ready", b_ir, 1);
            chk("t6_b_out_valid", b_ov, 1);
        end
        @(posedge clk); #1; a_iv = 1'b0; b_iv = 1'b0;
        repeat (6) @(posedge clk);

        // Asynchronous reset with words in flight
        #1; a_ordy = 1'b0; a_iv = 1'b1; a_id = 8'h91;
        b_ordy = 1'b0; b_iv = 1'b1; b_id = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t1_out_valid", a_ov, 0);
        chk("t1_occupancy", a_occ, 0);
        chk("t1_out_data", a_od, 8'h5A);
        chk("t1_b_out_data", b_od, 1'b1);
        a_iv = 1'b0; b_iv = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        // Randomized traffic with varying backpressure and occasional flush
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                @(posedge clk); #1;
                flush  = ($urandom_range(0, 47) == 0);
                a_iv   = ($urandom_range(0, 3) != 0);
                a_id   = 8'($urandom);
                a_ordy = ($urandom_range(0, 5) < blk);
                b_iv   = 1'($urandom);
                b_id   = 1'($urandom);
                b_ordy = ($urandom_range(0, 5) < blk);
            end
        end
        @(posedge clk); #1;
        flush = 1'b0; a_iv = 1'b0; b_iv = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
